regfile_mp: RTL and testbench

Parametrised multi-port general-purpose register file, successor to the single-write, two-read CPU register file. It provides NUM_RD combinational read ports and two write ports with fixed priority. Optional hard-wired zero register and same-cycle write-to-read bypass are selectable by parameter. A per-register pending-write scoreboard lets the pipeline stall on registers still waiting for writeback. It sits between decode (reads and issue) and writeback (writes) in the CPU core.

---
 rtl/regfile_mp.sv | 111 +++++++++++
 tb/tb_regfile_mp.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational reads, two prioritised write ports,
// optional zero register and write-to-read bypass, plus a pending-write scoreboard.
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          waddr0,
    input  logic [DATA_W-1:0]          wdata0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          waddr1,
    input  logic [DATA_W-1:0]          wdata1,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    output logic [NUM_RD-1:0]          busy,
    input  logic                       iss_valid,
    input  logic [ADDR_W-1:0]          iss_addr,
    output logic [ADDR_W:0]            pend_cnt
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic [DEPTH-1:0]  pend_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              wr0;
    logic              wr1;

    // Effective write enables: writes to register 0 vanish when it is hard-wired.
    always_comb begin
        wr0 = we0;
        wr1 = we1;
        if (ZERO_REG != 0) begin
            if (waddr0 == '0) wr0 = 1'b0;
            if (waddr1 == '0) wr1 = 1'b0;
        end
    end

    // Next scoreboard state; issue beats a same-cycle write because the new producer wins.
    always_comb begin
        pend_nxt = pend;
        cnt_nxt  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((wr0 && waddr0 == ADDR_W'(i)) || (wr1 && waddr1 == ADDR_W'(i)))
                pend_nxt[i] = 1'b0;
            if (iss_valid && iss_addr == ADDR_W'(i))
                pend_nxt[i] = 1'b1;
            if (ZERO_REG != 0 && i == 0)
                pend_nxt[i] = 1'b0;
            cnt_nxt = cnt_nxt + CNT_W'(pend_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr1 && waddr1 == ADDR_W'(i))
                    regs[i] <= wdata1;
                else if (wr0 && waddr0 == ADDR_W'(i))
                    regs[i] <= wdata0;
            end
            pend     <= pend_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

    // Read ports: stored value, optionally overridden by in-flight writes (port 1 last so it wins).
    always_comb begin
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] d;
        logic              b;
        rdata = '0;
        busy  = '0;
        ra    = '0;
        d     = '0;
        b     = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra = raddr[k*ADDR_W +: ADDR_W];
            d  = regs[ra];
            b  = pend[ra];
            if (BYPASS != 0) begin
                if (wr0 && waddr0 == ra) begin
                    d = wdata0;
                    b = 1'b0;
                end
                if (wr1 && waddr1 == ra) begin
                    d = wdata1;
                    b = 1'b0;
                end
            end
            if (ZERO_REG != 0 && ra == '0) begin
                d = '0;
                b = 1'b0;
            end
            rdata[k*DATA_W +: DATA_W] = d;
            busy[k]                   = b;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing and one non-bypassing instance share stimulus.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        we0, we1, iss_valid;
    logic [4:0]  waddr0, waddr1, iss_addr;
    logic [31:0] wdata0, wdata1;
    logic [9:0]  raddr;
    logic [63:0] rdata, rdata_nb;
    logic [1:0]  busy, busy_nb;
    logic [5:0]  pend_cnt, pend_cnt_nb;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst(rst),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata), .busy(busy),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .pend_cnt(pend_cnt)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata_nb), .busy(busy_nb),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .pend_cnt(pend_cnt_nb)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; we0 = 1'b0; we1 = 1'b0; iss_valid = 1'b0;
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; iss_addr = '0;
    endtask

    // Advance one edge, then settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        raddr = {5'd10, 5'd3};

        // Reset overrides a concurrent write.
        rst = 1'b1; we1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'hFFFF_FFFF;
        step();
        idle();
        #1;
        check("rst_rdata",    rdata,       64'h0);
        check("rst_rdata_nb", rdata_nb,    64'h0);
        check("rst_busy",     busy,        64'h0);
        check("rst_pend",     pend_cnt,    64'h0);
        check("rst_pend_nb",  pend_cnt_nb, 64'h0);

        // Dual write to same address: port 1 wins, also on the bypass path.
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h1111_1111;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h2222_2222;
        raddr = {5'd7, 5'd7};
        #1;
        check("coll_byp",    rdata,    64'h2222_2222_2222_2222);
        check("coll_nobyp",  rdata_nb, 64'h0);
        step();
        idle();
        #1;
        check("coll_stored",    rdata,    64'h2222_2222_2222_2222);
        check("coll_stored_nb", rdata_nb, 64'h2222_2222_2222_2222);

        // Different addresses: both land.
        we0 = 1'b1; waddr0 = 5'd8; wdata0 = 32'h0000_8888;
        we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h0000_9999;
        step();
        idle();
        raddr = {5'd9, 5'd8};
        #1;
        check("dual_land", rdata_nb, 64'h0000_9999_0000_8888);

        // Bypass versus stored-only read.
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hA;
        step();
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hB;
        raddr = {5'd8, 5'd5};
        #1;
        check("byp_new",   rdata,    64'h0000_8888_0000_000B);
        check("nobyp_old", rdata_nb, 64'h0000_8888_0000_000A);
        step();
        idle();
        #1;
        check("nobyp_after", rdata_nb, 64'h0000_8888_0000_000B);

        // Zero register: writes, bypass and issue all ignored.
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hDEAD_BEEF;
        we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hDEAD_BEEF;
        iss_valid = 1'b1; iss_addr = 5'd0;
        raddr = {5'd0, 5'd0};
        #1;
        check("zero_byp",  rdata, 64'h0);
        check("zero_busy", busy,  64'h0);
        step();
        idle();
        #1;
        check("zero_rdata",    rdata,    64'h0);
        check("zero_rdata_nb", rdata_nb, 64'h0);
        check("zero_busy_nb",  busy_nb,  64'h0);
        check("zero_pend",     pend_cnt, 64'h0);

        // Scoreboard: issue 4, 6, 4.
        iss_valid = 1'b1; iss_addr = 5'd4;
        step();
        check("sb_cnt1", pend_cnt, 64'd1);
        iss_addr = 5'd6;
        step();
        check("sb_cnt2", pend_cnt, 64'd2);
        iss_addr = 5'd4;
        step();
        check("sb_cnt_dup", pend_cnt, 64'd2);
        idle();
        raddr = {5'd6, 5'd4};
        #1;
        check("sb_busy", busy, 64'h3);

        // Write to pending reg 4: masked only with bypass, cleared after the edge.
        we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h44;
        #1;
        check("sb_mask",    busy,    64'h2);
        check("sb_nomask",  busy_nb, 64'h3);
        step();
        idle();
        #1;
        check("sb_clr_busy", busy,     64'h2);
        check("sb_clr_cnt",  pend_cnt, 64'd1);
        check("sb_clr_data", rdata[31:0], 64'h44);

        // Same-cycle issue and write of reg 6: stays pending.
        we1 = 1'b1; waddr1 = 5'd6; wdata1 = 32'h66;
        iss_valid = 1'b1; iss_addr = 5'd6;
        #1;
        check("sb_iw_mask", busy, 64'h0);
        step();
        idle();
        #1;
        check("sb_iw_cnt",  pend_cnt,     64'd1);
        check("sb_iw_busy", busy,         64'h2);
        check("sb_iw_data", rdata[63:32], 64'h66);

        // Write to a non-pending register leaves the count alone.
        we0 = 1'b1; waddr0 = 5'd10; wdata0 = 32'h10;
        step();
        idle();
        check("sb_np_cnt", pend_cnt, 64'd1);

        // Reset mid-operation with three pending registers and a concurrent issue.
        iss_valid = 1'b1; iss_addr = 5'd11;
        step();
        iss_addr = 5'd12;
        step();
        idle();
        check("mid_cnt3", pend_cnt, 64'd3);
        rst = 1'b1; iss_valid = 1'b1; iss_addr = 5'd13;
        we1 = 1'b1; waddr1 = 5'd14; wdata1 = 32'h1414;
        step();
        idle();
        raddr = {5'd6, 5'd11};
        #1;
        check("mid_cnt",    pend_cnt,    64'd0);
        check("mid_cnt_nb", pend_cnt_nb, 64'd0);
        check("mid_busy",   busy,        64'h0);
        raddr = {5'd7, 5'd5};
        #1;
        check("mid_rd_a", rdata, 64'h0);
        raddr = {5'd9, 5'd8};
        #1;
        check("mid_rd_b", rdata_nb, 64'h0);
        raddr = {5'd14, 5'd4};
        #1;
        check("mid_rd_c", rdata, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
